// File: rtl/scoreboard.sv
// Decode-stage issue scoreboard: per-register pending-write counters with RAW/WAW-saturation hold.
// Optional macro SB_R0_ZERO_EN makes register 0 a hardwired zero that is never tracked.
module scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rs1_i,
   input  logic        issue_rs1_used_i,
   input  logic [4:0]  issue_rs2_i,
   input  logic        issue_rs2_used_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        issue_rd_we_i,
   output logic        issue_ready_o,
   output logic        stall_o,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   input  logic        flush_i,
   output logic [31:0] pending_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [15:0] stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q [32];
   logic [31:0]      pend;
   logic [31:0]      ret;
   logic [31:0]      inc;
   logic [31:0]      eff_nz;
   logic [31:0]      eff_max;
   logic             raw;
   logic             sat;
   logic             fire;
   logic             underflow;
   logic             err_q;
   logic [15:0]      stall_cnt_q;

   // eff_nz/eff_max describe the count after a same-cycle retirement, mirroring register-file forwarding
   always_comb begin
      pend    = '0;
      ret     = '0;
      eff_nz  = '0;
      eff_max = '0;
      for (int i = 0; i < 32; i++) begin
         pend[i]    = (cnt_q[i] != '0);
         ret[i]     = wb_valid_i & (wb_rd_i == 5'(i)) & ~flush_i;
         eff_nz[i]  = pend[i] & ~((cnt_q[i] == CNT_W'(1)) & ret[i]);
         eff_max[i] = (cnt_q[i] == CNT_MAX) & ~ret[i];
      end
`ifdef SB_R0_ZERO_EN
      pend[0]    = 1'b0;
      ret[0]     = 1'b0;
      eff_nz[0]  = 1'b0;
      eff_max[0] = 1'b0;
`endif
   end

   always_comb begin
      raw           = (issue_rs1_used_i & eff_nz[issue_rs1_i]) |
                      (issue_rs2_used_i & eff_nz[issue_rs2_i]);
      sat           = issue_rd_we_i & eff_max[issue_rd_i];
      issue_ready_o = ~flush_i & ~raw & ~sat;
      stall_o       = issue_valid_i & ~issue_ready_o;
      fire          = issue_valid_i & issue_ready_o;
      underflow     = |(ret & ~pend);
   end

   always_comb begin
      inc = '0;
      if (fire & issue_rd_we_i) begin
         inc[issue_rd_i] = 1'b1;
      end
`ifdef SB_R0_ZERO_EN
      inc[0] = 1'b0;
`endif
   end

   // A simultaneous issue and retirement on the same register cancel out
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (flush_i) begin
               cnt_q[i] <= '0;
            end else if (inc[i] & ret[i]) begin
               cnt_q[i] <= cnt_q[i];
            end else if (inc[i]) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (ret[i] & pend[i]) begin
               cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (flush_i) begin
         err_q <= 1'b0;
      end else if (underflow) begin
         err_q <= 1'b1;
      end
   end

   // Stall count survives flushes; only reset clears it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign pending_o   = pend;
   assign busy_o      = |pend;
   assign err_o       = err_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
